ram_arbiter: RTL and testbench

Two-port arbiter and transaction sequencer in front of the single-port SPI RAM. It lets two independent command sources share the RAM's 10-bit command channel: bits [9:8] are the opcode (00 write address, 01 write data, 10 read address, 11 read data), and bits [7:0] are the payload. Because the RAM holds one shared address register, the arbiter locks the grant for a whole address+data transaction, then returns read data to the requester that issued it. A timeout frees the lock if a requester stalls.

---
 rtl/ram_arbiter.sv | 95 +++++++++
 tb/tb_ram_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester lock-based arbiter and transaction sequencer for a single-port SPI RAM.
// The grant is held for a whole address+data transaction; a stalled owner is released by timeout.
module ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [ADDR_SIZE+1:0] req0_din,
  output logic                 req0_ready,
  output logic [7:0]           req0_dout,
  output logic                 req0_dout_valid,
  input  logic                 req1_valid,
  input  logic [ADDR_SIZE+1:0] req1_din,
  output logic                 req1_ready,
  output logic [7:0]           req1_dout,
  output logic                 req1_dout_valid,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [7:0]           ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 owner,
  output logic                 busy,
  output logic                 lock_err
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, LOCK_WR, LOCK_RD, WAIT_RD} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_SIZE+1:0] ram_din_q;
  logic ram_rx_q, err_q, dv0_q, dv1_q;
  logic [7:0] dout0_q, dout1_q;
  logic gnt, cur, acc, legal, rd_done, tmo, err, done;
  logic [ADDR_SIZE+1:0] din;
  logic [1:0] op;
  // In IDLE the pointer only breaks ties; otherwise the lock holder is the only candidate
  assign gnt = (req0_valid & req1_valid) ? prio_q : req1_valid;
  assign cur = (state_q == IDLE) ? gnt : owner_q;
  assign din = cur ? req1_din : req0_din;
  assign op = din[ADDR_SIZE+1:ADDR_SIZE];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q <= 1'b0;
      cnt_q <= '0;
      ram_din_q <= '0;
      ram_rx_q <= 1'b0;
      err_q <= 1'b0;
      dv0_q <= 1'b0;
      dv1_q <= 1'b0;
      dout0_q <= '0;
      dout1_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q <= prio_d;
      cnt_q <= cnt_d;
      ram_rx_q <= acc & legal;
      if (acc & legal) ram_din_q <= din;
      err_q <= err;
      dv0_q <= rd_done & !owner_q;
      dv1_q <= rd_done & owner_q;
      if (rd_done & !owner_q) dout0_q <= ram_dout;
      if (rd_done & owner_q) dout1_q <= ram_dout;
    end
  end
  always_comb begin
    acc = cur ? req1_valid & req1_ready : req0_valid & req0_ready;
    legal = (state_q == IDLE) ? !op[0] : (state_q == LOCK_WR) ? !op[1] : (state_q == LOCK_RD) ? op[1] : 1'b0;
    rd_done = (state_q == WAIT_RD) & ram_tx_valid;
    tmo = (state_q != IDLE) & !acc & !rd_done & (cnt_q == '0);
    err = (acc & !legal) | tmo;
    done = err | rd_done | (acc & legal & (op == 2'b01));
    state_d = done ? IDLE : acc ? (op[1] ? (op[0] ? WAIT_RD : LOCK_RD) : LOCK_WR) : state_q;
    owner_d = acc ? cur : owner_q;
    prio_d = done ? !cur : prio_q;
    cnt_d = acc ? CW'(TIMEOUT - 1) : ((state_q != IDLE) && (cnt_q != '0)) ? cnt_q - 1'b1 : cnt_q;
  end
  always_comb begin
    req0_ready = (state_q == IDLE) ? req0_valid & !gnt : (state_q != WAIT_RD) & !owner_q;
    req1_ready = (state_q == IDLE) ? gnt : (state_q != WAIT_RD) & owner_q;
    busy = state_q != IDLE;
  end
  assign owner = owner_q;
  assign ram_din = ram_din_q;
  assign ram_rx_valid = ram_rx_q;
  assign lock_err = err_q;
  assign req0_dout = dout0_q;
  assign req1_dout = dout1_q;
  assign req0_dout_valid = dv0_q;
  assign req1_dout_valid = dv1_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized scoreboard bench for ram_arbiter
// against a transaction-level reference model.
module tb_ram_arbiter;
  localparam int TO = 4;
  localparam int P_IDLE = 0, P_WR = 1, P_RD = 2, P_WAIT = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, ram_tx_valid = 1'b0;
  logic [9:0] req0_din = '0, req1_din = '0;
  logic [7:0] ram_dout = '0;
  logic req0_ready, req1_ready, req0_dout_valid, req1_dout_valid;
  logic [7:0] req0_dout, req1_dout;
  logic [9:0] ram_din;
  logic ram_rx_valid, owner, busy, lock_err;

  ram_arbiter #(.ADDR_SIZE(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_din(req0_din), .req0_ready(req0_ready),
    .req0_dout(req0_dout), .req0_dout_valid(req0_dout_valid),
    .req1_valid(req1_valid), .req1_din(req1_din), .req1_ready(req1_ready),
    .req1_dout(req1_dout), .req1_dout_valid(req1_dout_valid),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .owner(owner), .busy(busy), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  typedef struct {int due; logic [9:0] val;} item_t;
  item_t ram_q[$], d0_q[$], d1_q[$], err_q[$];
  logic [9:0] prog0[$], prog1[$];
  int tests = 0, fails = 0, cyc = 0;
  int stall_pct = 0, tx_pct = 100;
  bit fix_dout = 1'b1;
  int m_phase = P_IDLE, m_owner = 0, m_prio = 0, m_idle = 0;
  item_t it;
  bit e;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every expected output event is due in exactly one cycle.
  always @(negedge clk) begin
    e = ram_q.size() != 0 && ram_q[0].due == cyc;
    chk("ram_rx_valid", ram_rx_valid, e);
    if (e) begin
      it = ram_q.pop_front();
      if (ram_rx_valid) chk("ram_din", ram_din, it.val);
    end
    e = d0_q.size() != 0 && d0_q[0].due == cyc;
    chk("req0_dout_valid", req0_dout_valid, e);
    if (e) begin
      it = d0_q.pop_front();
      if (req0_dout_valid) chk("req0_dout", req0_dout, it.val);
    end
    e = d1_q.size() != 0 && d1_q[0].due == cyc;
    chk("req1_dout_valid", req1_dout_valid, e);
    if (e) begin
      it = d1_q.pop_front();
      if (req1_dout_valid) chk("req1_dout", req1_dout, it.val);
    end
    e = err_q.size() != 0 && err_q[0].due == cyc;
    chk("lock_err", lock_err, e);
    if (e) void'(err_q.pop_front());
  end

  task automatic drive();
    req0_valid = prog0.size() != 0 && $urandom_range(99) >= stall_pct;
    req0_din = prog0.size() != 0 ? prog0[0] : 10'h0;
    req1_valid = prog1.size() != 0 && $urandom_range(99) >= stall_pct;
    req1_din = prog1.size() != 0 ? prog1[0] : 10'h0;
    ram_tx_valid = $urandom_range(99) < tx_pct;
    ram_dout = fix_dout ? 8'hA5 : 8'($urandom);
  endtask

  // One clock: check the model's view of this cycle, then advance the model across the edge.
  task automatic step();
    int g, who, op;
    bit e0, e1, acc, legal, ended, err;
    logic [9:0] w;
    @(negedge clk);
    if (rst) begin
      m_phase = P_IDLE;
      m_owner = 0;
      m_prio = 0;
      m_idle = 0;
    end else begin
      chk("busy", busy, m_phase != P_IDLE);
      chk("owner", owner, m_owner);
      g = (req0_valid && req1_valid) ? m_prio : (req1_valid ? 1 : 0);
      who = (m_phase == P_IDLE) ? g : m_owner;
      e0 = m_phase != P_WAIT && who == 0 && (m_phase != P_IDLE || req0_valid);
      e1 = m_phase != P_WAIT && who == 1;
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      acc = who == 1 ? (req1_valid && e1) : (req0_valid && e0);
      w = who == 1 ? req1_din : req0_din;
      ended = 0;
      err = 0;
      if (acc) begin
        op = int'(w[9:8]);
        legal = m_phase == P_IDLE ? (op == 0 || op == 2) : m_phase == P_WR ? op <= 1 : m_phase == P_RD ? op >= 2 : 0;
        if (legal) begin
          ram_q.push_back(item_t'{cyc + 1, w});
          ended = op == 1;
          m_phase = op == 0 ? P_WR : op == 2 ? P_RD : op == 3 ? P_WAIT : P_IDLE;
        end else begin
          err = 1;
          m_phase = P_IDLE;
        end
        m_owner = who;
        m_idle = 0;
        if (who == 1) void'(prog1.pop_front());
        else void'(prog0.pop_front());
      end else if (m_phase != P_IDLE) begin
        if (m_phase == P_WAIT && ram_tx_valid) begin
          if (m_owner == 1) d1_q.push_back(item_t'{cyc + 1, {2'b00, ram_dout}});
          else d0_q.push_back(item_t'{cyc + 1, {2'b00, ram_dout}});
          m_phase = P_IDLE;
          ended = 1;
        end else if (m_idle == TO - 1) begin
          err = 1;
          m_phase = P_IDLE;
        end else m_idle++;
      end
      if (err) begin
        err_q.push_back(item_t'{cyc + 1, 10'h0});
        ended = 1;
      end
      if (ended) m_prio = 1 - m_owner;
    end
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic check_zero();
    chk("rst_ram_din", ram_din, 0);
    chk("rst_ram_rx_valid", ram_rx_valid, 0);
    chk("rst_req0_dout", req0_dout, 0);
    chk("rst_req1_dout", req1_dout, 0);
    chk("rst_req0_dout_valid", req0_dout_valid, 0);
    chk("rst_req1_dout_valid", req1_dout_valid, 0);
    chk("rst_lock_err", lock_err, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive();
    step();
    rst = 1'b0;
    check_zero();
  endtask

  task automatic run_idle();
    for (int i = 0; i < 400 && (prog0.size() != 0 || prog1.size() != 0 || m_phase != P_IDLE); i++) step();
    chk("drain_left", prog0.size() + prog1.size() + m_phase, 0);
    step();
  endtask

  task automatic add_txn(input int r);
    logic [9:0] w[$];
    int k = $urandom_range(9);
    logic [7:0] a = 8'($urandom);
    if (k < 4) begin
      w.push_back({2'b00, a});
      if (k == 0) w.push_back({2'b00, 8'($urandom)});
      w.push_back({2'b01, 8'($urandom)});
    end else if (k < 8) begin
      w.push_back({2'b10, a});
      w.push_back({2'b11, 8'($urandom)});
    end else w.push_back(10'($urandom));
    foreach (w[i]) begin
      if (r == 1) prog1.push_back(w[i]);
      else prog0.push_back(w[i]);
    end
  endtask

  initial begin
    drive();
    step();
    do_reset();
    prog0 = '{10'h012, 10'h1A5, 10'h212, 10'h300};
    drive();
    run_idle();
    chk("req0_dout_hold", req0_dout, 8'hA5);
    prog0 = '{10'h010, 10'h133};
    prog1 = '{10'h020, 10'h144};
    do_reset();
    run_idle();
    prog0 = '{10'h210, 10'h3C3};
    prog1 = '{10'h0FF, 10'h111};
    tx_pct = 0;
    drive();
    repeat (6) step();
    tx_pct = 100;
    run_idle();
    prog1 = '{10'h1AA};
    drive();
    run_idle();
    prog0 = '{10'h000, 10'h100};
    prog1 = '{10'h200, 10'h300};
    drive();
    run_idle();
    prog0 = '{10'h005};
    drive();
    step();
    prog0 = '{};
    drive();
    repeat (6) step();
    prog0 = '{10'h006, 10'h107};
    prog1 = '{10'h008, 10'h109};
    drive();
    run_idle();
    prog0 = '{10'h230, 10'h300};
    tx_pct = 0;
    drive();
    repeat (5) step();
    chk("in_wait_rd", m_phase, P_WAIT);
    do_reset();
    tx_pct = 100;
    repeat (6) step();
    fix_dout = 1'b0;
    stall_pct = 30;
    tx_pct = 40;
    for (int i = 0; i < 3000; i++) begin
      if (prog0.size() == 0 && $urandom_range(3) == 0) add_txn(0);
      if (prog1.size() == 0 && $urandom_range(3) == 0) add_txn(1);
      step();
    end
    stall_pct = 0;
    run_idle();
    repeat (3) step();
    chk("ram_q_left", ram_q.size(), 0);
    chk("d0_q_left", d0_q.size(), 0);
    chk("d1_q_left", d1_q.size(), 0);
    chk("err_q_left", err_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
